bus_arbiter: RTL and testbench



---
 rtl/bus_arbiter_if.sv | 55 +++++
 rtl/bus_arbiter.sv | 133 +++++++++++++
 tb/tb_bus_arbiter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Bus bundle between the two core ports, the shared memory port and the arbiter.
interface bus_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);

   logic              req0_rd;
   logic              req0_wr;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_wdata;
   logic              req0_stall;
   logic              req0_done;
   logic [DATA_W-1:0] req0_rdata;

   logic              req1_rd;
   logic              req1_wr;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_wdata;
   logic              req1_stall;
   logic              req1_done;
   logic [DATA_W-1:0] req1_rdata;

   logic              mem_valid;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;

   logic              grant_id;
   logic              err;

   // Arbiter view: it owns the memory request and the per-core status.
   modport master (
      input  req0_rd, req0_wr, req0_addr, req0_wdata,
      input  req1_rd, req1_wr, req1_addr, req1_wdata,
      input  mem_ready, mem_rdata,
      output req0_stall, req0_done, req0_rdata,
      output req1_stall, req1_done, req1_rdata,
      output mem_valid, mem_we, mem_addr, mem_wdata,
      output grant_id, err
   );

   // Environment view: the cores and the memory that surround the arbiter.
   modport slave (
      output req0_rd, req0_wr, req0_addr, req0_wdata,
      output req1_rd, req1_wr, req1_addr, req1_wdata,
      output mem_ready, mem_rdata,
      input  req0_stall, req0_done, req0_rdata,
      input  req1_stall, req1_done, req1_rdata,
      input  mem_valid, mem_we, mem_addr, mem_wdata,
      input  grant_id, err
   );

endinterface

// File: rtl/bus_arbiter.sv
// Two-port round-robin arbiter sharing one memory bus between two cores,
// one transaction outstanding, with a bounded timeout on hung accesses.
module bus_arbiter #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input logic           CLK,
   input logic           RSTN,
   bus_arbiter_if.master bus
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   state_t            state_q, state_d;
   logic              grant_q, grant_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              timeout_q, timeout_d;

   logic              req0;
   logic              req1;
   logic              winner;

   assign req0 = bus.req0_rd | bus.req0_wr;
   assign req1 = bus.req1_rd | bus.req1_wr;

   // State register: FSM state, registered request copy, per-port read data.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q   <= IDLE;
         grant_q   <= 1'b1;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   // Next state: round-robin grant in IDLE, wait for ready or timeout in ISSUE.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata0_d  = rdata0_q;
      rdata1_d  = rdata1_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      winner    = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               if (req0 && req1) begin
                  winner = ~grant_q;
               end else begin
                  winner = req1;
               end
               grant_d   = winner;
               addr_d    = winner ? bus.req1_addr  : bus.req0_addr;
               wdata_d   = winner ? bus.req1_wdata : bus.req0_wdata;
               we_d      = winner ? bus.req1_wr    : bus.req0_wr;
               cnt_d     = '0;
               timeout_d = 1'b0;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            if (bus.mem_ready) begin
               if (grant_q) begin
                  rdata1_d = we_q ? '0 : bus.mem_rdata;
               end else begin
                  rdata0_d = we_q ? '0 : bus.mem_rdata;
               end
               state_d = DONE;
            end else if (cnt_q == TIMEOUT_CNT) begin
               if (grant_q) begin
                  rdata1_d = '0;
               end else begin
                  rdata0_d = '0;
               end
               timeout_d = 1'b1;
               state_d   = DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs: memory request from the registered copy, done/err/stall from state.
   always_comb begin
      bus.mem_valid  = (state_q == ISSUE);
      bus.mem_we     = we_q;
      bus.mem_addr   = addr_q;
      bus.mem_wdata  = wdata_q;
      bus.req0_done  = (state_q == DONE) && !grant_q;
      bus.req1_done  = (state_q == DONE) && grant_q;
      bus.req0_rdata = rdata0_q;
      bus.req1_rdata = rdata1_q;
      bus.req0_stall = req0 && !((state_q == DONE) && !grant_q);
      bus.req1_stall = req1 && !((state_q == DONE) && grant_q);
      bus.grant_id   = grant_q;
      bus.err        = (state_q == DONE) && timeout_q;
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a transaction model.
module tb_bus_arbiter;

   logic clk;
   logic rstn;

   int total = 0;
   int bad   = 0;

   bus_arbiter_if bus ();

   bus_arbiter dut (
      .CLK  (clk),
      .RSTN (rstn),
      .bus  (bus)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      int          core;
      bit          rd;
      bit          wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
      int          delay;
      logic [31:0] memData;
      bit          expWe;
      logic [31:0] expRdata;
      bit          expErr;
      int          expLatency;
   } vec_t;

   vec_t vecs[6];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic boundExpired(input string name);
      total++;
      bad++;
      $display("[TB] FAIL %s bound expired actual=none expected=event at %0t", name, $time);
   endtask

   task automatic driveReq(input int c, input bit rd, input bit wr, input logic [7:0] a, input logic [31:0] d);
      if (c == 0) begin
         bus.req0_rd    = rd;
         bus.req0_wr    = wr;
         bus.req0_addr  = a;
         bus.req0_wdata = d;
      end else begin
         bus.req1_rd    = rd;
         bus.req1_wr    = wr;
         bus.req1_addr  = a;
         bus.req1_wdata = d;
      end
   endtask

   function automatic logic getDone(input int c);
      return (c == 0) ? bus.req0_done : bus.req1_done;
   endfunction

   function automatic logic getStall(input int c);
      return (c == 0) ? bus.req0_stall : bus.req1_stall;
   endfunction

   function automatic logic [31:0] getRdata(input int c);
      return (c == 0) ? bus.req0_rdata : bus.req1_rdata;
   endfunction

   task automatic applyReset();
      rstn = 1'b0;
      driveReq(0, 1'b0, 1'b0, 8'h00, 32'h0);
      driveReq(1, 1'b0, 1'b0, 8'h00, 32'h0);
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   // One single-requester transaction from the vector table.
   task automatic applyStimulus(input vec_t v);
      int  cycles;
      int  issueIdx;
      bit  gotDone;
      driveReq(v.core, v.rd, v.wr, v.addr, v.wdata);
      #1;
      checkOutput("vecStallOnRaise", getStall(v.core), 1);
      cycles   = 0;
      issueIdx = 0;
      gotDone  = 0;
      bus.mem_ready = 1'b0;
      while (!gotDone && cycles < 40) begin
         step();
         cycles++;
         if (getDone(v.core)) begin
            gotDone = 1;
         end else if (bus.mem_valid) begin
            checkOutput("vecGrant", bus.grant_id, v.core);
            checkOutput("vecAddr", bus.mem_addr, v.addr);
            checkOutput("vecWe", bus.mem_we, v.expWe);
            checkOutput("vecWdata", bus.mem_wdata, v.wdata);
            bus.mem_ready = (issueIdx == v.delay);
            bus.mem_rdata = v.memData;
            issueIdx++;
         end else begin
            bus.mem_ready = 1'b0;
         end
      end
      if (!gotDone) begin
         boundExpired("vecDone");
      end else begin
         checkOutput("vecLatency", cycles, v.expLatency);
         checkOutput("vecRdata", getRdata(v.core), v.expRdata);
         checkOutput("vecErr", bus.err, v.expErr);
         checkOutput("vecStallAtDone", getStall(v.core), 0);
         checkOutput("vecOtherDone", getDone(1 - v.core), 0);
         checkOutput("vecValidAtDone", bus.mem_valid, 0);
      end
      driveReq(v.core, 1'b0, 1'b0, 8'h00, 32'h0);
      bus.mem_ready = 1'b0;
      step();
      checkOutput("vecIdleDone", getDone(v.core), 0);
      checkOutput("vecIdleErr", bus.err, 0);
   endtask

   // Randomized run checked against a transaction-level reference model.
   task automatic randomRun(input int numCycles);
      int          mState;
      int          winner;
      int          lastGrant;
      int          elapsed;
      int          delay;
      bit          tmo;
      bit          readyDriven;
      logic [31:0] dataDriven;
      logic [31:0] mRdata[2];
      bit          p[2];
      bit          rdv[2];
      bit          wrv[2];
      logic [7:0]  av[2];
      logic [31:0] dv[2];
      bit          latWe;
      logic [7:0]  latA;
      logic [31:0] latD;
      bit          dropped[2];
      int          op;

      mState      = 0;
      winner      = 0;
      lastGrant   = 1;
      elapsed     = 0;
      delay       = 0;
      tmo         = 0;
      readyDriven = 0;
      dataDriven  = 32'h0;
      latWe       = 0;
      latA        = 8'h0;
      latD        = 32'h0;
      for (int c = 0; c < 2; c++) begin
         mRdata[c] = 32'h0;
         p[c]      = 0;
         rdv[c]    = 0;
         wrv[c]    = 0;
         av[c]     = 8'h0;
         dv[c]     = 32'h0;
      end

      for (int cyc = 0; cyc < numCycles; cyc++) begin
         step();

         if (mState == 0) begin
            if (p[0] || p[1]) begin
               winner    = (p[0] && p[1]) ? (1 - lastGrant) : (p[0] ? 0 : 1);
               lastGrant = winner;
               latA      = av[winner];
               latD      = dv[winner];
               latWe     = wrv[winner];
               elapsed   = 0;
               delay     = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4));
               mState    = 1;
            end
         end else if (mState == 1) begin
            if (readyDriven) begin
               mRdata[winner] = latWe ? 32'h0 : dataDriven;
               tmo    = 0;
               mState = 2;
            end else if (elapsed == 15) begin
               mRdata[winner] = 32'h0;
               tmo    = 1;
               mState = 2;
            end else begin
               elapsed++;
            end
         end else begin
            mState = 0;
         end

         checkOutput("rndValid", bus.mem_valid, (mState == 1));
         checkOutput("rndGrant", bus.grant_id, lastGrant);
         if (mState == 1) begin
            checkOutput("rndAddr", bus.mem_addr, latA);
            checkOutput("rndWe", bus.mem_we, latWe);
            checkOutput("rndWdata", bus.mem_wdata, latD);
         end
         checkOutput("rndDone0", bus.req0_done, (mState == 2) && (winner == 0));
         checkOutput("rndDone1", bus.req1_done, (mState == 2) && (winner == 1));
         checkOutput("rndErr", bus.err, (mState == 2) && tmo);
         checkOutput("rndRdata0", bus.req0_rdata, mRdata[0]);
         checkOutput("rndRdata1", bus.req1_rdata, mRdata[1]);
         checkOutput("rndStall0", bus.req0_stall, p[0] && !((mState == 2) && (winner == 0)));
         checkOutput("rndStall1", bus.req1_stall, p[1] && !((mState == 2) && (winner == 1)));

         dropped[0] = 0;
         dropped[1] = 0;
         if (mState == 2) begin
            p[winner]       = 0;
            rdv[winner]     = 0;
            wrv[winner]     = 0;
            dropped[winner] = 1;
            driveReq(winner, 1'b0, 1'b0, $urandom_range(0, 255), $urandom);
         end
         for (int c = 0; c < 2; c++) begin
            if (!p[c] && !dropped[c] && cyc < numCycles - 60 && $urandom_range(0, 2) == 0) begin
               op     = $urandom_range(1, 3);
               rdv[c] = op[0];
               wrv[c] = op[1];
               av[c]  = 8'($urandom_range(0, 255));
               dv[c]  = $urandom;
               p[c]   = 1;
               driveReq(c, rdv[c], wrv[c], av[c], dv[c]);
            end
         end

         if (mState == 1) begin
            readyDriven   = (elapsed == delay);
            bus.mem_ready = readyDriven;
         end else begin
            readyDriven   = 0;
            bus.mem_ready = 1'($urandom_range(0, 1));
         end
         dataDriven    = $urandom;
         bus.mem_rdata = dataDriven;
      end
      bus.mem_ready = 1'b0;
      checkOutput("rndDrainedValid", bus.mem_valid, 0);
      checkOutput("rndDrainedStall0", bus.req0_stall, 0);
      checkOutput("rndDrainedStall1", bus.req1_stall, 0);
   endtask

   initial begin
      int grants[4];
      int n;
      int cycles;

      vecs[0] = '{core:0, rd:1, wr:0, addr:8'h05, wdata:32'h0, delay:0, memData:32'hDEADBEEF,
                  expWe:0, expRdata:32'hDEADBEEF, expErr:0, expLatency:2};
      vecs[1] = '{core:1, rd:0, wr:1, addr:8'h10, wdata:32'h00000001, delay:0, memData:32'h11111111,
                  expWe:1, expRdata:32'h0, expErr:0, expLatency:2};
      vecs[2] = '{core:0, rd:0, wr:1, addr:8'hFF, wdata:32'hA5A55A5A, delay:3, memData:32'h22222222,
                  expWe:1, expRdata:32'h0, expErr:0, expLatency:5};
      vecs[3] = '{core:1, rd:1, wr:1, addr:8'h33, wdata:32'h0BEEF000, delay:1, memData:32'h12345678,
                  expWe:1, expRdata:32'h0, expErr:0, expLatency:3};
      vecs[4] = '{core:0, rd:1, wr:0, addr:8'h80, wdata:32'h0, delay:20, memData:32'h33333333,
                  expWe:0, expRdata:32'h0, expErr:1, expLatency:17};
      vecs[5] = '{core:1, rd:1, wr:0, addr:8'h7F, wdata:32'h0, delay:15, memData:32'hCAFEF00D,
                  expWe:0, expRdata:32'hCAFEF00D, expErr:0, expLatency:17};

      applyReset();
      checkOutput("rstValid", bus.mem_valid, 0);
      checkOutput("rstGrant", bus.grant_id, 1);
      checkOutput("rstAddr", bus.mem_addr, 0);
      checkOutput("rstWe", bus.mem_we, 0);
      checkOutput("rstWdata", bus.mem_wdata, 0);
      checkOutput("rstRdata0", bus.req0_rdata, 0);
      checkOutput("rstRdata1", bus.req1_rdata, 0);
      checkOutput("rstDone0", bus.req0_done, 0);
      checkOutput("rstDone1", bus.req1_done, 0);
      checkOutput("rstErr", bus.err, 0);

      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i]);
      end

      // Simultaneous requests straight after reset: core0 wins the first tie.
      applyReset();
      driveReq(0, 1'b0, 1'b1, 8'h10, 32'h00000001);
      driveReq(1, 1'b1, 1'b0, 8'h20, 32'h0);
      #1;
      checkOutput("tieStall0Raise", bus.req0_stall, 1);
      checkOutput("tieStall1Raise", bus.req1_stall, 1);
      step();
      checkOutput("tieValidA", bus.mem_valid, 1);
      checkOutput("tieGrantA", bus.grant_id, 0);
      checkOutput("tieAddrA", bus.mem_addr, 8'h10);
      checkOutput("tieWeA", bus.mem_we, 1);
      checkOutput("tieWdataA", bus.mem_wdata, 32'h1);
      bus.mem_ready = 1'b1;
      step();
      checkOutput("tieDone0", bus.req0_done, 1);
      checkOutput("tieDone1Low", bus.req1_done, 0);
      checkOutput("tieStall0Done", bus.req0_stall, 0);
      checkOutput("tieStall1Held", bus.req1_stall, 1);
      driveReq(0, 1'b0, 1'b0, 8'h00, 32'h0);
      bus.mem_ready = 1'b0;
      step();
      checkOutput("tieIdleValid", bus.mem_valid, 0);
      checkOutput("tieIdleStall1", bus.req1_stall, 1);
      step();
      checkOutput("tieValidB", bus.mem_valid, 1);
      checkOutput("tieGrantB", bus.grant_id, 1);
      checkOutput("tieAddrB", bus.mem_addr, 8'h20);
      checkOutput("tieWeB", bus.mem_we, 0);
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h55AA55AA;
      step();
      checkOutput("tieDone1", bus.req1_done, 1);
      checkOutput("tieRdata1", bus.req1_rdata, 32'h55AA55AA);
      driveReq(1, 1'b0, 1'b0, 8'h00, 32'h0);
      bus.mem_ready = 1'b0;
      step();

      // Both cores request continuously: grants must alternate.
      driveReq(0, 1'b1, 1'b0, 8'h01, 32'h0);
      driveReq(1, 1'b1, 1'b0, 8'h02, 32'h0);
      n = 0;
      cycles = 0;
      while (n < 4 && cycles < 40) begin
         step();
         cycles++;
         if (bus.req0_done || bus.req1_done) begin
            grants[n] = bus.req1_done ? 1 : 0;
            n++;
            bus.mem_ready = 1'b0;
         end else if (bus.mem_valid) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = 32'h0000_0100 + 32'(n);
         end else begin
            bus.mem_ready = 1'b0;
         end
      end
      if (n < 4) begin
         boundExpired("rrTransactions");
      end else begin
         for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("rrGrant%0d", i), grants[i], i % 2);
         end
      end
      driveReq(0, 1'b0, 1'b0, 8'h00, 32'h0);
      driveReq(1, 1'b0, 1'b0, 8'h00, 32'h0);
      bus.mem_ready = 1'b0;
      repeat (2) step();

      // Reset pulled mid-ISSUE: request drops asynchronously, then normal service.
      applyReset();
      driveReq(0, 1'b1, 1'b0, 8'h42, 32'h0);
      step();
      checkOutput("midRstValidBefore", bus.mem_valid, 1);
      #3;
      rstn = 1'b0;
      #1;
      checkOutput("midRstValid", bus.mem_valid, 0);
      checkOutput("midRstDone0", bus.req0_done, 0);
      checkOutput("midRstErr", bus.err, 0);
      driveReq(0, 1'b0, 1'b0, 8'h00, 32'h0);
      @(posedge clk);
      #1;
      checkOutput("midRstHeldValid", bus.mem_valid, 0);
      rstn = 1'b1;
      step();
      driveReq(0, 1'b1, 1'b0, 8'h42, 32'h0);
      step();
      checkOutput("postRstValid", bus.mem_valid, 1);
      checkOutput("postRstGrant", bus.grant_id, 0);
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h0BADCAFE;
      step();
      checkOutput("postRstDone0", bus.req0_done, 1);
      checkOutput("postRstRdata0", bus.req0_rdata, 32'h0BADCAFE);
      driveReq(0, 1'b0, 1'b0, 8'h00, 32'h0);
      bus.mem_ready = 1'b0;
      step();

      applyReset();
      randomRun(1000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
